// File: rtl/fifo_rd_stream_pkg.sv
// +----------------------------------------------------------------------------+
// | fifo_rd_stream_pkg: shared widths, constants and stream-beat type for the  |
// | FIFO read/write stream adapters.                                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package fifo_rd_stream_pkg;

  // Only registered-output (show-ahead-off) FIFOs with one cycle of read latency.
  localparam int c_RD_LATENCY  = 1;
  localparam int c_BEAT_DWIDTH = 16;

  typedef struct packed {
    logic [c_BEAT_DWIDTH-1:0] data;
    logic                     sop;
    logic                     eop;
  } stream_beat_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_buf.sv
// +----------------------------------------------------------------------------+
// | stream_buf: DEPTH-entry circular register buffer with push/pop, occupancy  |
// | and head-of-queue outputs.                                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module stream_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 2,
  localparam int OW    = occ_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] push_data_i,
  input  logic              pop_i,
  output logic [OW-1:0]     occ_o,
  output logic [DWIDTH-1:0] head_o
);

  localparam int              c_PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [OW-1:0]     r_occ;

  // Entries are cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wr_ptr] <= push_data_i;
        r_wr_ptr        <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (pop_i) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      r_occ <= r_occ + OW'(push_i) - OW'(pop_i);
    end
  end

  assign occ_o  = r_occ;
  assign head_o = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
// +----------------------------------------------------------------------------+
// | fifo_rd_stream: read-side adapter turning a show-ahead-off FIFO into a     |
// | valid/ready packet stream with sop/eop framing.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int LWIDTH     = 8,
  parameter int BUF_DEPTH  = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rdreq_o,
  input  logic [LWIDTH-1:0] pkt_len_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sop_o,
  output logic              eop_o,
  output logic [LWIDTH-1:0] pkt_cnt_o
);

  localparam int c_OW = occ_width(BUF_DEPTH);

  logic [c_OW-1:0] w_occ;
  logic [c_OW:0]   w_credit;
  logic            r_inflight;
  logic            w_pop;

  assign w_pop   = valid_o && ready_i;
  assign valid_o = (w_occ != '0);

  // Space still owed after this cycle's pop; ready_i reaches fifo_rdreq_o
  // combinationally, so that path must be constrained at the integration level.
  assign w_credit     = {1'b0, w_occ} + (c_OW+1)'(r_inflight) - (c_OW+1)'(w_pop);
  assign fifo_rdreq_o = !fifo_empty_i && (w_credit < (c_OW+1)'(BUF_DEPTH));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rdreq_o;
    end
  end

  // The credit rule reserves a slot for every in-flight word, so capture is unconditional.
  stream_buf #(
    .DWIDTH (DWIDTH),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (r_inflight),
    .push_data_i (fifo_q_i),
    .pop_i       (w_pop),
    .occ_o       (w_occ),
    .head_o      (data_o)
  );

  logic [LWIDTH-1:0] r_cnt;
  logic [LWIDTH-1:0] r_len;
  logic [LWIDTH-1:0] w_len;
  logic [LWIDTH:0]   w_len_ext;
  logic              w_last;

  // A zero length field encodes the full 2**LWIDTH-word packet.
  assign w_len     = (r_cnt == '0) ? pkt_len_i : r_len;
  assign w_len_ext = (w_len == '0) ? {1'b1, {LWIDTH{1'b0}}} : {1'b0, w_len};
  assign w_last    = ({1'b0, r_cnt} == (w_len_ext - (LWIDTH+1)'(1)));

  assign sop_o     = (r_cnt == '0);
  assign eop_o     = valid_o && w_last;
  assign pkt_cnt_o = r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_len <= '0;
    end else if (w_pop) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == '0) begin
          r_len <= pkt_len_i;
        end
      end
    end
  end

  a_occ_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    w_occ <= c_OW'(BUF_DEPTH));

  a_params : assert property (@(posedge clk_i)
    (BUF_DEPTH >= 2) && (RD_LATENCY == c_RD_LATENCY));

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// +----------------------------------------------------------------------------+
// | tb_fifo_rd_stream: directed bench with a show-ahead-off FIFO model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_rd_stream;

  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] fifo_q_i;
  logic          fifo_empty_i;
  logic          fifo_rdreq_o;
  logic [LW-1:0] pkt_len_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          sop_o;
  logic          eop_o;
  logic [LW-1:0] pkt_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  fifo_rd_stream #(.DWIDTH(DW), .LWIDTH(LW), .BUF_DEPTH(2), .RD_LATENCY(1)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fifo_q_i     (fifo_q_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdreq_o (fifo_rdreq_o),
    .pkt_len_i    (pkt_len_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .sop_o        (sop_o),
    .eop_o        (eop_o),
    .pkt_cnt_o    (pkt_cnt_o)
  );

  // Show-ahead-off FIFO: q is registered one cycle after an accepted read.
  logic [DW-1:0] fmem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty_i = (wr_ptr == rd_ptr);

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr   <= wr_ptr;
      fifo_q_i <= '0;
    end else if (fifo_rdreq_o && !fifo_empty_i) begin
      fifo_q_i <= fmem[rd_ptr];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  // Reference occupancy / in-flight model.
  int mocc  = 0;
  int minfl = 0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mocc  <= 0;
      minfl <= 0;
    end else begin
      mocc  <= mocc + minfl - (((mocc != 0) && ready_i) ? 1 : 0);
      minfl <= (fifo_rdreq_o && !fifo_empty_i) ? 1 : 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    fmem[wr_ptr] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    ready_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  // Entered at edge+1; receives n words and compares against the framing model.
  task automatic recv(input int n, input int base, input int len, input int start_pos,
                      input bit toggle, input int budget);
    int k;
    int cyc;
    int L;
    int pos;
    k   = 0;
    cyc = 0;
    L   = (len == 0) ? 256 : len;
    while (k < n && cyc < budget) begin
      ready_i = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      #1;
      check("valid_vs_model", valid_o, mocc != 0);
      check("occ_vs_model", dut.w_occ, mocc);
      if (toggle && !ready_i && (mocc + minfl >= 2))
        check("rdreq_held_off", fifo_rdreq_o, 1'b0);
      if (valid_o && ready_i) begin
        pos = (start_pos + k) % L;
        check("data", data_o, base + k);
        check("sop", sop_o, pos == 0);
        check("eop", eop_o, pos == L - 1);
        check("pkt_cnt", pkt_cnt_o, pos);
        k = k + 1;
      end
      @(posedge clk_i);
      #1;
      cyc = cyc + 1;
    end
    check("recv_count", k, n);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [LW-1:0] cnt;
  } vec_t;

  vec_t t1 [8];

  initial begin
    int w;

    t1[0] = '{16'h0001, 1'b1, 1'b0, 8'd0};
    t1[1] = '{16'h0002, 1'b0, 1'b0, 8'd1};
    t1[2] = '{16'h0003, 1'b0, 1'b0, 8'd2};
    t1[3] = '{16'h0004, 1'b0, 1'b1, 8'd3};
    t1[4] = '{16'h0005, 1'b1, 1'b0, 8'd0};
    t1[5] = '{16'h0006, 1'b0, 1'b0, 8'd1};
    t1[6] = '{16'h0007, 1'b0, 1'b0, 8'd2};
    t1[7] = '{16'h0008, 1'b0, 1'b1, 8'd3};

    pkt_len_i = 8'd4;
    do_reset();
    #1;
    check("rst_valid", valid_o, 1'b0);
    check("rst_rdreq", fifo_rdreq_o, 1'b0);
    check("rst_sop", sop_o, 1'b1);
    check("rst_eop", eop_o, 1'b0);
    check("rst_cnt", pkt_cnt_o, 8'd0);
    check("rst_data", data_o, 16'h0000);

    // Full-rate stream, two 4-word packets.
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    w = 0;
    while (!valid_o && w < 10) begin
      @(posedge clk_i);
      #2;
      w = w + 1;
    end
    for (int i = 0; i < 8; i++) begin
      check("t1_valid", valid_o, 1'b1);
      check("t1_data", data_o, t1[i].data);
      check("t1_sop", sop_o, t1[i].sop);
      check("t1_eop", eop_o, t1[i].eop);
      check("t1_cnt", pkt_cnt_o, t1[i].cnt);
      @(posedge clk_i);
      #2;
    end
    check("t1_drained", valid_o, 1'b0);

    // Same stream under 1,0,0,1 backpressure.
    do_reset();
    for (int i = 1; i <= 8; i++) push(DW'(i));
    recv(8, 1, 4, 0, 1'b1, 60);

    // Single-word packets.
    do_reset();
    pkt_len_i = 8'd1;
    for (int i = 0; i < 3; i++) push(DW'(16'h0100 + i));
    recv(3, 16'h0100, 1, 0, 1'b0, 20);

    // Length 0 encodes 256 words.
    do_reset();
    pkt_len_i = 8'd0;
    for (int i = 0; i < 300; i++) push(DW'(16'h1000 + i));
    recv(300, 16'h1000, 0, 0, 1'b0, 400);

    // FIFO runs dry mid-packet; length change during the gap is ignored.
    do_reset();
    pkt_len_i = 8'd4;
    push(16'h0001);
    push(16'h0002);
    recv(2, 1, 4, 0, 1'b0, 20);
    pkt_len_i = 8'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("gap_valid", valid_o, 1'b0);
      check("gap_cnt", pkt_cnt_o, 8'd2);
      @(posedge clk_i);
      #1;
    end
    push(16'h0003);
    push(16'h0004);
    recv(2, 3, 4, 2, 1'b0, 20);

    // Asynchronous reset with a full buffer and a non-empty FIFO.
    do_reset();
    pkt_len_i = 8'd4;
    for (int i = 0; i < 5; i++) push(DW'(16'h0010 + i));
    repeat (4) @(posedge clk_i);
    #1;
    check("pre_rst_valid", valid_o, 1'b1);
    check("pre_rst_occ", dut.w_occ, 2);
    #2 rst_i = 1'b1;
    #1;
    check("arst_valid", valid_o, 1'b0);
    check("arst_rdreq", fifo_rdreq_o, 1'b0);
    check("arst_sop", sop_o, 1'b1);
    check("arst_eop", eop_o, 1'b0);
    check("arst_cnt", pkt_cnt_o, 8'd0);
    check("arst_data", data_o, 16'h0000);
    check("arst_occ", dut.w_occ, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    push(16'hAAAA);
    recv(1, 16'hAAAA, 4, 0, 1'b0, 10);
    repeat (3) @(posedge clk_i);
    #2;
    check("post_rst_no_stale", valid_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
